controller: RTL and testbench
=============================

Name: controller

Overview:
- Control unit of the multicycle RV32I core.
- Moore FSM that sequences fetch, decode, execute, memory and writeback, and drives every mux select and write enable of the datapath.
- Takes opcode, funct3, funct7 bit 5 and the ALU Zero flag from the datapath.
- Sits beside the datapath under the board top.

Parameters:
None.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH
op  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
funct7b5  in  1  instruction[30]
Zero  in  1  ALU result == 0
ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result, 11 ImmExt
MemWrite  out  1  memory write enable
PCSrc  out  1  branch-taken flag
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register
ALUSrcB  out  2  00 rs2 register, 01 ImmExt, 10 constant 4
AdrSrc  out  1  0 PC, 1 Result
RegWrite  out  1  register file write enable
Jump  out  1  high in JAL/JALR/JALR2 states
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
IRWrite  out  1  instruction register load
PCWrite  out  1  PC load

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- State register is named cycle_state (enum, readable by name in simulation).
- On reset, cycle_state = FETCH.
- While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- All other outputs follow the current state combinationally.
- Default for every output is 0, except where a state listed below sets it.
- ImmSrc is decoded from op in every state:
  - load/jalr/I-ALU -> 000
  - store -> 001
  - branch -> 010
  - jal -> 011
  - lui/auipc -> 100
  - anything else -> 000
- ALU decode by funct3 (EXECUTER, EXECUTEI):
  - 000: add; sub only if op is R-type and funct7b5 = 1
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: sra if funct7b5 = 1, else srl
  - 110: or
  - 111: and
- Opcodes:
  - load 0000011, store 0100011, R-type 0110011, I-ALU 0010011
  - branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111
- States, their outputs and next state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (computes branch/jal target). Next by op: load/store -> MEMADR, R -> EXECUTER, I-ALU -> EXECUTEI, branch -> BRANCH, jal -> JAL, jalr -> JALR, lui -> LUI, auipc -> AUIPC, other -> FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD for load, MEMWRITE for store.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, decoded op. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, decoded op. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00. Next: FETCH.
    - ALU op: sub for beq/bne; slt for blt/bge; sltu for bltu/bgeu.
    - PCSrc = Zero for beq/bge/bgeu; PCSrc = !Zero for bne/blt/bltu; PCSrc = 0 for funct3 010/011.
    - PCWrite = PCSrc.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, Jump=1. Next: ALUWB.
  - JALR: ALUSrcA=10, ALUSrcB=01, add, Jump=1. Next: JALR2.
  - JALR2: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, Jump=1. Next: ALUWB.
  - LUI: ResultSrc=11, RegWrite=1. Next: FETCH.
  - AUIPC: ALUSrcA=01, ALUSrcB=01, add. Next: ALUWB.
- Cycle counts per instruction:
  - lui, branch: 3
  - R-type, I-ALU, store, jal, auipc: 4
  - load, jalr: 5
- Reset asserted mid-instruction abandons it; execution restarts at FETCH once reset deasserts.

Optional Feature:
- Macro CTRL_HALT_ON_ILLEGAL_EN.
- Defined: an unknown opcode in DECODE moves to state HALT.
  - HALT drives all enables to 0 and stays there until reset.
- Undefined: an unknown opcode returns to FETCH (treated as a NOP); HALT does not exist.

Test Plan:
- Reset asserted asynchronously mid-MEMREAD -> cycle_state=FETCH immediately, all enables 0; after release the first cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- op=0110011, funct3=000, funct7b5=1 -> FETCH, DECODE, EXECUTER with ALUControl=0001, ALUWB with RegWrite=1; back in FETCH on cycle 5.
- op=0000011 -> FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1).
- op=1100011: funct3=001 with Zero=0 -> PCSrc=1, PCWrite=1, ALUControl=0001; funct3=101 with Zero=0 -> PCSrc=0, ALUControl=0101.
- op=1100111 -> JALR then JALR2 with PCWrite=1 and Jump=1, then ALUWB with RegWrite=1; 5 cycles total.
- op=0110111 -> LUI with ResultSrc=11, RegWrite=1, ImmSrc=100; op=0000000 -> FETCH after DECODE, or HALT when CTRL_HALT_ON_ILLEGAL_EN is defined.

Source files
------------

// File: rtl/controller.sv
`timescale 1ns/1ps
// controller: Moore control FSM of the multicycle RV32I core; drives every datapath select and enable.
// Optional build macro CTRL_HALT_ON_ILLEGAL_EN parks the FSM in HALT on an unknown opcode.
module controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ResultSrc,
    output logic       MemWrite,
    output logic       PCSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       AdrSrc,
    output logic       RegWrite,
    output logic       Jump,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
        ALUWB, BRANCH, JAL, JALR, JALR2, LUI, AUIPC
`ifdef CTRL_HALT_ON_ILLEGAL_EN
        , HALT
`endif
    } state_e;

    state_e     cycle_state, cycle_state_d;
    logic [3:0] alu_dec, br_alu;
    logic       br_taken;
    logic       ir_en, pc_en, rw_en, mw_en;

    // NOTE: the state register uses non-blocking assignment; all combinational blocks use blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_state <= FETCH;
        else       cycle_state <= cycle_state_d;
    end

    always_comb begin
        cycle_state_d = FETCH;
        unique case (cycle_state)
            FETCH:    cycle_state_d = DECODE;
            DECODE: begin
                unique case (op)
                    OP_LOAD, OP_STORE: cycle_state_d = MEMADR;
                    OP_R:              cycle_state_d = EXECUTER;
                    OP_IALU:           cycle_state_d = EXECUTEI;
                    OP_BR:             cycle_state_d = BRANCH;
                    OP_JAL:            cycle_state_d = JAL;
                    OP_JALR:           cycle_state_d = JALR;
                    OP_LUI:            cycle_state_d = LUI;
                    OP_AUIPC:          cycle_state_d = AUIPC;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
                    default:           cycle_state_d = HALT;
`else
                    default:           cycle_state_d = FETCH;
`endif
                endcase
            end
            MEMADR:   cycle_state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  cycle_state_d = MEMWB;
            EXECUTER, EXECUTEI, JAL, JALR2, AUIPC: cycle_state_d = ALUWB;
            JALR:     cycle_state_d = JALR2;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
            HALT:     cycle_state_d = HALT;
`endif
            default:  cycle_state_d = FETCH;
        endcase
    end

    // ALU operation for register/immediate arithmetic; only R-type can select sub.
    always_comb begin
        alu_dec = ALU_ADD;
        unique case (funct3)
            3'b000: alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_dec = ALU_SLL;
            3'b010: alu_dec = ALU_SLT;
            3'b011: alu_dec = ALU_SLTU;
            3'b100: alu_dec = ALU_XOR;
            3'b101: alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_dec = ALU_OR;
            3'b111: alu_dec = ALU_AND;
        endcase
    end

    // Branch compare and whether a zero/non-zero result means taken.
    always_comb begin
        br_alu   = ALU_ADD;
        br_taken = 1'b0;
        unique case (funct3)
            3'b000: begin br_alu = ALU_SUB;  br_taken = Zero;  end
            3'b001: begin br_alu = ALU_SUB;  br_taken = !Zero; end
            3'b100: begin br_alu = ALU_SLT;  br_taken = !Zero; end
            3'b101: begin br_alu = ALU_SLT;  br_taken = Zero;  end
            3'b110: begin br_alu = ALU_SLTU; br_taken = !Zero; end
            3'b111: begin br_alu = ALU_SLTU; br_taken = Zero;  end
            default: ;
        endcase
    end

    always_comb begin
        unique case (op)
            OP_STORE:          ImmSrc = 3'b001;
            OP_BR:             ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        // NOTE: every output is defaulted first so no state leaves one unassigned and no latch appears.
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        AdrSrc     = 1'b0;
        Jump       = 1'b0;
        PCSrc      = 1'b0;
        ALUControl = ALU_ADD;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        rw_en      = 1'b0;
        mw_en      = 1'b0;
        unique case (cycle_state)
            FETCH:    begin ir_en = 1'b1; pc_en = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = 2'b01; rw_en = 1'b1; end
            MEMWRITE: begin AdrSrc = 1'b1; mw_en = 1'b1; end
            EXECUTER: begin ALUSrcA = 2'b10; ALUControl = alu_dec; end
            EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = alu_dec; end
            ALUWB:    rw_en = 1'b1;
            BRANCH:   begin ALUSrcA = 2'b10; ALUControl = br_alu; PCSrc = br_taken; pc_en = br_taken; end
            JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_en = 1'b1; Jump = 1'b1; end
            JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; Jump = 1'b1; end
            JALR2:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_en = 1'b1; Jump = 1'b1; end
            LUI:      begin ResultSrc = 2'b11; rw_en = 1'b1; end
            AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            default: ;
        endcase
    end

    // Architectural enables are suppressed for as long as reset is held.
    assign IRWrite  = ir_en & ~reset;
    assign PCWrite  = pc_en & ~reset;
    assign RegWrite = rw_en & ~reset;
    assign MemWrite = mw_en & ~reset;
endmodule

// File: tb/tb_controller.sv
`timescale 1ns/1ps
// tb_controller: randomized instruction stream checked cycle-by-cycle against a per-instruction step model.
// Also honours CTRL_HALT_ON_ILLEGAL_EN when the design is built with it.
module tb_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic       MemWrite, PCSrc, AdrSrc, RegWrite, Jump, IRWrite, PCWrite;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {C_LOAD, C_STORE, C_R, C_I, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_e;

    controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .ResultSrc(ResultSrc), .MemWrite(MemWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .AdrSrc(AdrSrc), .RegWrite(RegWrite), .Jump(Jump), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {ResultSrc, MemWrite, PCSrc, ALUSrcA, ALUSrcB, AdrSrc, RegWrite, Jump,
                  ImmSrc, ALUControl, IRWrite, PCWrite};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic cls_e class_of(input logic [6:0] o);
        case (o)
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int cycles_of(input cls_e c);
        case (c)
            C_LOAD, C_JALR:                  return 5;
            C_STORE, C_R, C_I, C_JAL, C_AUIPC: return 4;
            C_BR, C_LUI:                     return 3;
            default:                         return 2;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (class_of(o))
            C_STORE:         return 3'b001;
            C_BR:            return 3'b010;
            C_JAL:           return 3'b011;
            C_LUI, C_AUIPC:  return 3'b100;
            default:         return 3'b000;
        endcase
    endfunction

    // Arithmetic operation named by funct3: add sll slt sltu xor srl/sra or and.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (f3 == 3'b000 && is_r && f7) return 4'd1;
        if (f3 == 3'b101 && f7)         return 4'd9;
        return tab[f3];
    endfunction

    function automatic logic [3:0] br_op(input logic [2:0] f3);
        case (f3[2:1])
            2'b00:   return 4'd1;
            2'b10:   return 4'd5;
            2'b11:   return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic br_take(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000, 3'b101, 3'b111: return z;
            3'b001, 3'b100, 3'b110: return !z;
            default:                return 1'b0;
        endcase
    endfunction

    // Expected outputs for step s (0 = fetch, 1 = decode) of an instruction of class c.
    function automatic logic [19:0] model(input cls_e c, input int s, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic z);
        logic [1:0] res, a, b;
        logic       mw, pcs, adr, rw, j, ir, pcw;
        logic [3:0] alu;
        res = 2'b00; a = 2'b00; b = 2'b00; alu = 4'd0;
        mw = 0; pcs = 0; adr = 0; rw = 0; j = 0; ir = 0; pcw = 0;
        if (s == 0) begin ir = 1; pcw = 1; b = 2'b10; res = 2'b10; end
        else if (s == 1) begin a = 2'b01; b = 2'b01; end
        else begin
            case (c)
                C_LOAD:  if (s == 2) begin a = 2; b = 1; end
                         else if (s == 3) adr = 1;
                         else begin res = 2'b01; rw = 1; end
                C_STORE: if (s == 2) begin a = 2; b = 1; end else begin adr = 1; mw = 1; end
                C_R:     if (s == 2) begin a = 2; alu = arith_op(f3, f7, 1'b1); end else rw = 1;
                C_I:     if (s == 2) begin a = 2; b = 1; alu = arith_op(f3, f7, 1'b0); end else rw = 1;
                C_BR:    begin a = 2; alu = br_op(f3); pcs = br_take(f3, z); pcw = pcs; end
                C_JAL:   if (s == 2) begin a = 1; b = 2; pcw = 1; j = 1; end else rw = 1;
                C_JALR:  if (s == 2) begin a = 2; b = 1; j = 1; end
                         else if (s == 3) begin a = 1; b = 2; pcw = 1; j = 1; end
                         else rw = 1;
                C_LUI:   begin res = 2'b11; rw = 1; end
                C_AUIPC: if (s == 2) begin a = 1; b = 1; end else rw = 1;
                default: ;
            endcase
        end
        return {res, mw, pcs, a, b, adr, rw, j, imm_of(o), alu, ir, pcw};
    endfunction

    // While reset is held the FSM sits in FETCH with every enable forced low.
    function automatic logic [19:0] reset_vec(input logic [6:0] o);
        return {2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, imm_of(o), 4'd0, 1'b0, 1'b0};
    endfunction

    // Called shortly after a negedge; returns shortly after a later negedge with reset released.
    task automatic reset_mid();
        reset = 1'b1;
        #1;
        check("rst_async", obs, reset_vec(op));
        @(negedge clk);
        #1;
        check("rst_hold", obs, reset_vec(op));
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH; abort >= 0 asserts reset after checking that step.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int abort);
        cls_e c;
        int   n;
        c = class_of(o);
        n = cycles_of(c);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        for (int s = 0; s < n; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            check($sformatf("op%b_f3%b_f7%b_z%b_s%0d", o, f3, f7, z, s), obs, model(c, s, o, f3, f7, z));
            if (s == abort) begin
                reset_mid();
                return;
            end
        end
`ifdef CTRL_HALT_ON_ILLEGAL_EN
        if (c == C_ILL) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                #1;
                check("halt", obs, {15'd0, 5'd0} | {12'd0, imm_of(o), 5'd0});
            end
            reset_mid();
            return;
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] legal [9];
        logic [6:0] o;
        int         ab;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        #1;
        check("reset_init", obs, reset_vec(op));
        @(negedge clk);
        #1;
        reset = 1'b0;

        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, -1);  // sub
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3);   // load, reset during MEMREAD
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b1, -1);
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, -1);  // bne taken
        run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, -1);  // bge not taken
        run_instr(7'b1100011, 3'b010, 1'b0, 1'b1, -1);  // undefined branch funct3
        run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, -1);  // jalr
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, -1);  // lui
        run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, -1);  // srai
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, -1);  // addi ignores funct7b5
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, -1);  // illegal
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b1, -1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do o = 7'($urandom_range(0, 127)); while (class_of(o) != C_ILL);
            end else begin
                o = legal[$urandom_range(0, 8)];
            end
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, cycles_of(class_of(o)) - 1)) : -1;
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
